fp_mult_responder: RTL and testbench
====================================

Name: fp_mult_responder

Overview:
- Responder end of the accumulator's ALU start/data_ready handshake: sequential IEEE-754 multiplier driving the mult_result / mult_data_ready pair.
- Accepts a one-cycle mult_start with operand_a/operand_b and computes a*b with an iterative shift-add mantissa multiplier.
- Returns the product with a one-cycle data_ready pulse.
- The consumer ORs all ALU results together, so mult_result is zero whenever mult_data_ready is low.

Parameters:
EXP_LEN, 8, exponent field width; bias = 2^(EXP_LEN-1)-1
MANTISSA_LEN, 23, stored fraction width; DATA_WIDTH = 1+EXP_LEN+MANTISSA_LEN (localparam)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
mult_start  input  1  one-cycle request; operands valid in the same cycle
operand_a  input  DATA_WIDTH  multiplicand {sign, exp, frac}
operand_b  input  DATA_WIDTH  multiplier {sign, exp, frac}
mult_result  output  DATA_WIDTH  product; all-zero except while mult_data_ready=1
mult_data_ready  output  1  one-cycle result-valid pulse
busy  output  1  high from acceptance until the data_ready cycle inclusive

Behaviour:
- Reset (reset=0, async): state=IDLE; mult_result=0, mult_data_ready=0, busy=0; internal registers cleared.
- Reset mid-operation aborts the operation. No data_ready pulse is produced for the aborted request.
- IDLE: mult_start=1 latches operands, goes to UNPACK, busy=1. mult_start outside IDLE is ignored; no queueing.
- UNPACK: sign=a.s^b.s; exp_sum=ea+eb-bias as signed (EXP_LEN+2)-bit value. Mantissas get hidden bit 1 prepended, giving MANTISSA_LEN+1 bits. Special flags:
  - zero_flag: either exp field==0. Denormals are flushed to zero.
  - inf_flag: either exp field all-ones. NaN is not supported; all-ones exp is treated as inf.
  - zero_flag has priority over inf_flag.
- MULT: MANTISSA_LEN+1 iterations, one multiplier bit per cycle (LSB first). Product accumulated in a 2*(MANTISSA_LEN+1)-bit register.
- NORM:
  - If product MSB=1: shift right 1 and exp_sum+1.
  - Keep the MANTISSA_LEN fraction bits below the leading 1.
  - Retain guard bit and sticky bit (OR of all lower bits).
- PACK: round per the Optional Feature. Mantissa carry-out from rounding renormalises and increments exp. Then, in priority order:
  - zero_flag → {sign, 0}
  - inf_flag or exp ≥ all-ones → {sign, all-ones exp, 0 frac}
  - exp ≤ 0 → {sign, 0}
  - otherwise → {sign, exp, frac}
- DONE: the registered result appears with mult_data_ready=1 for exactly one cycle. Next cycle: mult_result=0, mult_data_ready=0, busy=0, state=IDLE.
- Fixed latency, independent of operand values including specials:
  - Start sampled at edge 0; data_ready rises at edge MANTISSA_LEN+4 (27 with defaults).
  - Back-to-back: a new start is accepted at the first edge after the data_ready cycle.
- If mult_start is held high, the block re-triggers on the first IDLE edge. The consumer must pulse start.

Optional Feature:
Macro: FP_MULT_RNE_EN
- Defined: round-to-nearest-even in PACK.
  - Increment when guard=1 and (sticky=1 or frac LSB=1).
  - Overflow from the increment is handled as above.
- Undefined: truncation; guard/sticky logic is not generated.
- Latency is identical in both builds.

Test Plan:
- Reset low mid-MULT (edge 10), then released → no data_ready pulse; outputs 0, busy=0. A fresh start 0x3F800000*0x3F800000 → 0x3F800000.
- Start 0x40000000*0x40400000 (2*3) → data_ready exactly at edge 27, mult_result=0x40C00000. mult_result=0 on the cycles before and after.
- Start 0xC0000000*0x3F000000 → 0xBF800000. Start 0x3FC00000*0x3FC00000 → 0x40100000. The second start is issued at edge 28, and a dummy start pulsed at edge 5 is ignored.
- Specials:
  - 0x00000000*0x7F7FFFFF → 0x00000000
  - 0x80000000*0x3F800000 → 0x80000000
  - 0x7F000000*0x7F000000 → 0x7F800000
  - 0x00800000*0x00800000 → 0x00000000
  - 0x7F800000*0x00000000 → 0x00000000
- Rounding: 0x3F800001*0x3FC00000 → 0x3FC00001 without FP_MULT_RNE_EN, 0x3FC00002 with it. 0x3F800001*0x3F800001 → 0x3F800002 in both builds.
- Randomised 1,000 normal-range pairs against a reference model (truncate or RNE per build). Each result is checked only in its data_ready cycle, and mult_result=0 is checked everywhere else.

Source files
------------

// File: rtl/fp_mult_responder.sv
// -----------------------------------------------------------------------------
// fp_mult_responder
//   Sequential IEEE-754 style multiplier acting as the responder side of the
//   accumulator's ALU start/data_ready handshake. A one-cycle mult_start
//   captures both operands, an iterative shift-add loop forms the mantissa
//   product (one multiplier bit per cycle, LSB first), and the packed result
//   is presented for exactly one cycle alongside mult_data_ready.
//
//   Latency is fixed at MANTISSA_LEN+4 edges from the accepting edge to the
//   data_ready edge, regardless of operand values.
//
//   Denormals flush to zero, an all-ones exponent is always treated as
//   infinity (no NaN), and zero wins over infinity.
//
//   Build option: define FP_MULT_RNE_EN for round-to-nearest-even. Without it
//   the fraction is truncated and no guard/sticky state exists.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous active-low reset, aborts any operation
//   mult_start       one-cycle request, operands valid in the same cycle
//   operand_a/b      {sign, exponent, fraction}
//   mult_result      product, forced to zero except while mult_data_ready=1
//   mult_data_ready  one-cycle result-valid pulse
//   busy             high from acceptance through the data_ready cycle
// -----------------------------------------------------------------------------
module fp_mult_responder #(
   parameter int EXP_LEN      = 8,
   parameter int MANTISSA_LEN = 23,
   localparam int DATA_WIDTH  = 1 + EXP_LEN + MANTISSA_LEN
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mult_start,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   output logic [DATA_WIDTH-1:0] mult_result,
   output logic                  mult_data_ready,
   output logic                  busy
);

   localparam int MW = MANTISSA_LEN + 1;   // mantissa with hidden bit
   localparam int PW = 2 * MW;             // full product width
   localparam int EW = EXP_LEN + 2;        // signed exponent working width
   localparam int CW = $clog2(MW + 1);

   localparam logic [CW-1:0]        LAST_ITER = CW'(MW - 1);
   localparam logic signed [EW-1:0] BIAS_E    = EW'((1 << (EXP_LEN - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_LEN) - 1);
   localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
   localparam logic signed [EW-1:0] EXP_ZERO  = EW'(0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_MULT   = 3'd2,
      S_NORM   = 3'd3,
      S_PACK   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic [DATA_WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic                      sign_q, sign_d;
   logic signed [EW-1:0]      exp_q, exp_d;
   logic                      zero_q, zero_d, inf_q, inf_d;
   logic [PW-1:0]             mcand_q, mcand_d, prod_q, prod_d;
   logic [MW-1:0]             mplier_q, mplier_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [MANTISSA_LEN-1:0]   frac_q, frac_d;
`ifdef FP_MULT_RNE_EN
   logic                      guard_q, guard_d, sticky_q, sticky_d;
`endif
   logic [DATA_WIDTH-1:0]     result_q, result_d;
   logic                      ready_q, ready_d, busy_q, busy_d;

   logic                      round_inc_s;
   logic [MANTISSA_LEN:0]     round_mant_s;
   logic signed [EW-1:0]      exp_rnd_s;
   logic [DATA_WIDTH-1:0]     pack_s;

   // State and datapath registers, cleared by the asynchronous reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         zero_q   <= 1'b0;
         inf_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         frac_q   <= '0;
`ifdef FP_MULT_RNE_EN
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
`endif
         result_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         zero_q   <= zero_d;
         inf_q    <= inf_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         frac_q   <= frac_d;
`ifdef FP_MULT_RNE_EN
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
`endif
         result_q <= result_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   // Rounding and final packing of the normalised fraction
   always_comb begin
      round_inc_s = 1'b0;
`ifdef FP_MULT_RNE_EN
      round_inc_s = guard_q & (sticky_q | frac_q[0]);
`endif
      round_mant_s = {1'b0, frac_q} + {{MANTISSA_LEN{1'b0}}, round_inc_s};
      // A carry out of the fraction means 1.111..1 rounded up to 10.000..0,
      // whose fraction field is already zero, so only the exponent moves.
      exp_rnd_s = exp_q + (round_mant_s[MANTISSA_LEN] ? EXP_ONE : EXP_ZERO);
      if (zero_q) begin
         pack_s = {sign_q, {(DATA_WIDTH-1){1'b0}}};
      end else if (inf_q || (exp_rnd_s >= EXP_MAX)) begin
         pack_s = {sign_q, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
      end else if (exp_rnd_s <= EXP_ZERO) begin
         pack_s = {sign_q, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         pack_s = {sign_q, exp_rnd_s[EXP_LEN-1:0], round_mant_s[MANTISSA_LEN-1:0]};
      end
   end

   // Next-state and datapath sequencing
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      zero_d   = zero_q;
      inf_d    = inf_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      frac_d   = frac_q;
`ifdef FP_MULT_RNE_EN
      guard_d  = guard_q;
      sticky_d = sticky_q;
`endif
      result_d = '0;
      ready_d  = 1'b0;
      busy_d   = busy_q;

      case (state_q)
         S_IDLE: begin
            if (mult_start) begin
               a_d     = operand_a;
               b_d     = operand_b;
               busy_d  = 1'b1;
               state_d = S_UNPACK;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_UNPACK: begin
            sign_d   = a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1];
            exp_d    = $signed({2'b00, a_q[DATA_WIDTH-2 -: EXP_LEN]})
                     + $signed({2'b00, b_q[DATA_WIDTH-2 -: EXP_LEN]}) - BIAS_E;
            zero_d   = (a_q[DATA_WIDTH-2 -: EXP_LEN] == '0) ||
                       (b_q[DATA_WIDTH-2 -: EXP_LEN] == '0);
            inf_d    = (&a_q[DATA_WIDTH-2 -: EXP_LEN]) ||
                       (&b_q[DATA_WIDTH-2 -: EXP_LEN]);
            mcand_d  = {{MW{1'b0}}, 1'b1, a_q[MANTISSA_LEN-1:0]};
            mplier_d = {1'b1, b_q[MANTISSA_LEN-1:0]};
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = S_MULT;
         end
         S_MULT: begin
            if (mplier_q[0]) begin
               prod_d = prod_q + mcand_q;
            end else begin
               prod_d = prod_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = S_NORM;
            end else begin
               state_d = S_MULT;
            end
         end
         S_NORM: begin
            // Product of two [1,2) mantissas lies in [1,4): either the top
            // bit or the one below it is the leading one.
            if (prod_q[PW-1]) begin
               frac_d   = prod_q[PW-2 -: MANTISSA_LEN];
               exp_d    = exp_q + EXP_ONE;
`ifdef FP_MULT_RNE_EN
               guard_d  = prod_q[PW-2-MANTISSA_LEN];
               sticky_d = |prod_q[PW-3-MANTISSA_LEN:0];
`endif
            end else begin
               frac_d   = prod_q[PW-3 -: MANTISSA_LEN];
`ifdef FP_MULT_RNE_EN
               guard_d  = prod_q[PW-3-MANTISSA_LEN];
               sticky_d = |prod_q[PW-4-MANTISSA_LEN:0];
`endif
            end
            state_d = S_PACK;
         end
         S_PACK: begin
            result_d = pack_s;
            ready_d  = 1'b1;
            busy_d   = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            // The data_ready cycle may already accept the next request so
            // back-to-back operations lose no cycle.
            if (mult_start) begin
               a_d     = operand_a;
               b_d     = operand_b;
               busy_d  = 1'b1;
               state_d = S_UNPACK;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign mult_result     = result_q;
   assign mult_data_ready = ready_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_fp_mult_responder.sv
// -----------------------------------------------------------------------------
// tb_fp_mult_responder
//   Table-driven bench for fp_mult_responder with default parameters (binary32).
//   Each applied request pushes its expected product onto a scoreboard queue;
//   a negedge monitor pops and compares on every data_ready cycle and demands
//   mult_result==0 on every other cycle. Expected values come from constants
//   and an independent reference multiplier (64-bit integer product,
//   remainder-vs-half rounding decision).
// -----------------------------------------------------------------------------
module tb_fp_mult_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mult_start = 1'b0;
   logic [31:0] operand_a = 32'd0;
   logic [31:0] operand_b = 32'd0;
   logic [31:0] mult_result;
   logic        mult_data_ready;
   logic        busy;

   int          vectors = 0;
   int          miscompares = 0;
   bit          mon_en = 1'b0;
   logic [31:0] expq[$];
   logic [31:0] mon_exp;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      bit          dummy;
   } vec_t;

   vec_t vecs[$];

   fp_mult_responder dut (
      .clock           (clock),
      .reset           (reset),
      .mult_start      (mult_start),
      .operand_a       (operand_a),
      .operand_b       (operand_b),
      .mult_result     (mult_result),
      .mult_data_ready (mult_data_ready),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   // Reference binary32 multiply, flush-to-zero, all-ones exponent is inf
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic            s;
      int              ea, eb, e, sh;
      longint unsigned p, frac;
`ifdef FP_MULT_RNE_EN
      longint unsigned rem, half;
`endif
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 0 || eb == 0) return {s, 31'd0};
      if (ea == 255 || eb == 255) return {s, 8'hFF, 23'd0};
      p = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
      e = ea + eb - 127;
      if (p[47]) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      frac = (p >> sh) & 64'h7F_FFFF;
`ifdef FP_MULT_RNE_EN
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && frac[0])) frac = frac + 64'd1;
      if (frac == 64'h80_0000) begin
         frac = 64'd0;
         e    = e + 1;
      end
`endif
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, e[7:0], frac[22:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic add_vec(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] y, input bit dummy);
      vec_t v;
      v.a = a; v.b = b; v.y = y; v.dummy = dummy;
      vecs.push_back(v);
   endtask

   // Scoreboard: compare in data_ready cycles, require zero elsewhere
   always @(negedge clock) begin
      if (mon_en) begin
         if (mult_data_ready) begin
            if (expq.size() == 0) begin
               miscompares++;
               $display("FAIL spurious_ready: result %h with no request pending", mult_result);
            end else begin
               mon_exp = expq.pop_front();
               vectors++;
               if (mult_result !== mon_exp) begin
                  miscompares++;
                  $display("FAIL product #%0d: got %h expected %h", vectors, mult_result, mon_exp);
               end
            end
         end else if (mult_result !== 32'd0) begin
            miscompares++;
            $display("FAIL result_idle_zero: got %h expected 00000000", mult_result);
         end
      end
   end

   // One request; start sampled at edge 0, data_ready must appear at edge 27
   task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] y, input bit dummy);
      int k;
      @(negedge clock);
      operand_a  = a;
      operand_b  = b;
      mult_start = 1'b1;
      expq.push_back(y);
      @(posedge clock);
      #1 chk("busy_after_accept", {31'd0, busy}, 32'd1);
      for (k = 1; k <= 40; k++) begin
         @(negedge clock);
         mult_start = dummy && (k == 5);
         if (dummy && k == 5) begin
            operand_a = $urandom;
            operand_b = $urandom;
         end
         @(posedge clock);
         #1;
         if (mult_data_ready) break;
      end
      chk("latency", k, 32'd27);
      chk("busy_in_ready_cycle", {31'd0, busy}, 32'd1);
   endtask

   initial begin
      // Fixed vectors, including the back-to-back pair with an ignored dummy start
      add_vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
      add_vec(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);
      add_vec(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 1'b1);
      add_vec(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0);
      add_vec(32'h0000_0000, 32'h7F7F_FFFF, 32'h0000_0000, 1'b0);
      add_vec(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 1'b0);
      add_vec(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b0);
      add_vec(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0);
      add_vec(32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
`ifdef FP_MULT_RNE_EN
      add_vec(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 1'b0);
`else
      add_vec(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 1'b0);
`endif
      add_vec(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] ra, rb;
         ra = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
         rb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
         add_vec(ra, rb, ref_mul(ra, rb), 1'b0);
      end

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("reset_result", mult_result, 32'd0);
      chk("reset_ready", {31'd0, mult_data_ready}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset  = 1'b1;
      mon_en = 1'b1;

      // Abort mid-MULT: reset at edge 10, no data_ready may follow
      @(negedge clock);
      operand_a  = 32'h4000_0000;
      operand_b  = 32'h4040_0000;
      mult_start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      mult_start = 1'b0;
      repeat (9) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_ready", {31'd0, mult_data_ready}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      repeat (35) @(posedge clock);
      #1 chk("abort_busy_after", {31'd0, busy}, 32'd0);

      // Table: every entry back-to-back, next start at the edge after data_ready
      foreach (vecs[i]) run_one(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].dummy);

      repeat (3) @(posedge clock);
      #1;
      chk("final_busy", {31'd0, busy}, 32'd0);
      chk("scoreboard_drained", expq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
